// File: rtl/acc_stream_arbiter.sv
// rtl/acc_stream_arbiter.sv - packet-granular round-robin arbiter feeding the accumulator stream input
module acc_stream_arbiter #(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 16
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic [DATA_W-1:0] s0_axis_data,
    input  logic              s0_axis_valid,
    input  logic              s0_axis_last,
    output logic              s0_axis_ready,
    input  logic [DATA_W-1:0] s1_axis_data,
    input  logic              s1_axis_valid,
    input  logic              s1_axis_last,
    output logic              s1_axis_ready,
    output logic [DATA_W-1:0] m_axis_data,
    output logic              m_axis_valid,
    output logic              m_axis_last,
    input  logic              m_axis_ready,
    output logic [1:0]        o_grant,
    output logic              o_pkt_done,
    output logic              o_pkt_src,
    output logic              o_trunc,
    output logic [CNT_W-1:0]  o_pkt_cnt0,
    output logic [CNT_W-1:0]  o_pkt_cnt1
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [15:0]      LAST_BEAT = 16'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_nxt;
    logic        last_srv;
    logic [15:0] beat_cnt;
    logic        beat;
    logic        done;
    logic        src_last;
    logic        cur_port;

    assign cur_port = (state == GNT1);

    always_comb begin
        state_nxt     = state;
        s0_axis_ready = 1'b0;
        s1_axis_ready = 1'b0;
        m_axis_data   = '0;
        m_axis_valid  = 1'b0;
        m_axis_last   = 1'b0;
        src_last      = 1'b0;
        beat          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                // On contention the port not served last wins
                if (s0_axis_valid && s1_axis_valid)
                    state_nxt = last_srv ? GNT0 : GNT1;
                else if (s0_axis_valid)
                    state_nxt = GNT0;
                else if (s1_axis_valid)
                    state_nxt = GNT1;
            end
            GNT0: begin
                m_axis_data   = s0_axis_data;
                m_axis_valid  = s0_axis_valid;
                s0_axis_ready = m_axis_ready;
                src_last      = s0_axis_last;
                beat          = s0_axis_valid && m_axis_ready;
            end
            GNT1: begin
                m_axis_data   = s1_axis_data;
                m_axis_valid  = s1_axis_valid;
                s1_axis_ready = m_axis_ready;
                src_last      = s1_axis_last;
                beat          = s1_axis_valid && m_axis_ready;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            // Oversized packets are cut at MAX_BEATS; the rest arrives as a new packet
            m_axis_last = src_last || (beat_cnt == LAST_BEAT);
            done        = beat && m_axis_last;
            if (done)
                state_nxt = IDLE;
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state      <= IDLE;
            last_srv   <= 1'b1;
            beat_cnt   <= '0;
            o_grant    <= 2'b00;
            o_pkt_done <= 1'b0;
            o_pkt_src  <= 1'b0;
            o_trunc    <= 1'b0;
            o_pkt_cnt0 <= '0;
            o_pkt_cnt1 <= '0;
        end else begin
            state      <= state_nxt;
            o_grant    <= {state_nxt == GNT1, state_nxt == GNT0};
            o_pkt_done <= done;
            o_trunc    <= done && !src_last;
            if (done) begin
                beat_cnt  <= '0;
                last_srv  <= cur_port;
                o_pkt_src <= cur_port;
                if (cur_port)
                    o_pkt_cnt1 <= o_pkt_cnt1 + CNT_ONE;
                else
                    o_pkt_cnt0 <= o_pkt_cnt0 + CNT_ONE;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_acc_stream_arbiter.sv
// tb/tb_acc_stream_arbiter.sv - self-checking bench for acc_stream_arbiter
module tb_acc_stream_arbiter;

    localparam int MAXB = 4;
    localparam int CNTW = 2;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        bit         r0;
        bit         r1;
        logic [1:0] exp_grant;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] sd [2];
    logic        sv [2];
    logic        sl [2];
    logic        sr0, sr1;
    logic [31:0] m_data;
    logic        m_valid, m_last, m_ready;
    logic [1:0]  grant;
    logic        pkt_done, pkt_src, trunc;
    logic [CNTW-1:0] cnt0, cnt1;

    acc_stream_arbiter #(.DATA_W(32), .MAX_BEATS(MAXB), .CNT_W(CNTW)) dut (
        .axi_clk(clk), .axi_rst(rst),
        .s0_axis_data(sd[0]), .s0_axis_valid(sv[0]), .s0_axis_last(sl[0]), .s0_axis_ready(sr0),
        .s1_axis_data(sd[1]), .s1_axis_valid(sv[1]), .s1_axis_last(sl[1]), .s1_axis_ready(sr1),
        .m_axis_data(m_data), .m_axis_valid(m_valid), .m_axis_last(m_last), .m_axis_ready(m_ready),
        .o_grant(grant), .o_pkt_done(pkt_done), .o_pkt_src(pkt_src), .o_trunc(trunc),
        .o_pkt_cnt0(cnt0), .o_pkt_cnt1(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    beat_t srcq [2][$];
    bit    held [2];
    int    vpct = 100;
    int    rmode = 0;

    // reference model: who holds the stream, beats so far, who was served last
    int mg, mb, mlast, msrc;
    int mcnt [2];
    bit mdone, mtrunc;

    logic [31:0] out_q [$];
    bit          out_last [$];
    int          gnt_order [$];
    logic [1:0]  prev_grant;
    int n_done, n_trunc, bubbles, cyc;
    int first_valid_cyc, first_beat_cyc, last_beat_cyc, done_cyc;
    bit s0r_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mg = -1; mb = 0; mlast = 1; msrc = 0;
        mcnt[0] = 0; mcnt[1] = 0;
        mdone = 0; mtrunc = 0;
    endtask

    task automatic clear_src();
        for (int p = 0; p < 2; p++) begin
            srcq[p].delete();
            held[p] = 0;
            sv[p] = 0;
        end
    endtask

    task automatic stats_reset();
        out_q.delete(); out_last.delete(); gnt_order.delete();
        prev_grant = grant;
        n_done = 0; n_trunc = 0; bubbles = 0; cyc = 0; s0r_seen = 0;
        first_valid_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    endtask

    task automatic push_pkt(input int p, input int len, input int base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = {8'(p), 24'(base + i)};
            b.l = (i == len - 1);
            srcq[p].push_back(b);
        end
    endtask

    task automatic cycle();
        bit e_r0, e_r1, e_v, e_l;
        logic [1:0] e_g;
        logic [12:0] e_vec, a_vec;
        bit hs [2];
        for (int p = 0; p < 2; p++) begin
            if (srcq[p].size() > 0) begin
                sv[p] = held[p] ? 1'b1 : ($urandom_range(99) < vpct);
                sd[p] = srcq[p][0].d;
                sl[p] = srcq[p][0].l;
            end else begin
                sv[p] = 1'b0;
                sd[p] = '0;
                sl[p] = 1'b0;
            end
        end
        if (rmode == 0) m_ready = 1'b1;
        else if (rmode == 1) m_ready = ~m_ready;
        else m_ready = 1'($urandom_range(1));
        #1;
        e_r0 = (mg == 0) && m_ready;
        e_r1 = (mg == 1) && m_ready;
        e_v  = (mg >= 0) && sv[mg];
        e_l  = (mg >= 0) && (sl[mg] || (mb + 1 == MAXB));
        e_g  = (mg < 0) ? 2'b00 : ((mg == 0) ? 2'b01 : 2'b10);
        e_vec = {e_r0, e_r1, e_v, e_l, e_g, mdone, 1'(msrc), mtrunc, 2'(mcnt[0]), 2'(mcnt[1])};
        a_vec = {sr0, sr1, m_valid, m_last, grant, pkt_done, pkt_src, trunc, cnt0, cnt1};
        chk("cycle_outputs", 32'(a_vec), 32'(e_vec));
        if (e_v) chk("cycle_data", m_data, sd[mg]);
        if ((sv[0] || sv[1]) && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            out_last.push_back(m_last);
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            if (m_last) last_beat_cyc = cyc;
        end
        if (pkt_done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (trunc) n_trunc++;
        if (sr0) s0r_seen = 1;
        if (grant != 2'b00 && prev_grant == 2'b00) gnt_order.push_back(grant == 2'b10 ? 1 : 0);
        if (grant == 2'b00 && gnt_order.size() > 0 && (srcq[0].size() > 0 || srcq[1].size() > 0))
            bubbles++;
        prev_grant = grant;
        hs[0] = sv[0] && sr0;
        hs[1] = sv[1] && sr1;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (hs[p]) void'(srcq[p].pop_front());
            held[p] = sv[p] && !hs[p];
        end
        mdone = 0; mtrunc = 0;
        if (mg < 0) begin
            if (sv[0] && sv[1]) mg = 1 - mlast;
            else if (sv[0]) mg = 0;
            else if (sv[1]) mg = 1;
        end else if (sv[mg] && m_ready) begin
            mb++;
            if (e_l) begin
                mdone = 1; mtrunc = !sl[mg]; msrc = mg; mlast = mg;
                mcnt[mg] = (mcnt[mg] + 1) % (1 << CNTW);
                mb = 0; mg = -1;
            end
        end
        cyc++;
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while ((srcq[0].size() > 0 || srcq[1].size() > 0 || mg >= 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_bound", 32'(n < budget), 1);
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    vec_t tbl [8];
    int   bad;

    initial begin
        tbl[0] = '{1, 1, 2'b01};
        tbl[1] = '{1, 0, 2'b01};
        tbl[2] = '{1, 1, 2'b10};
        tbl[3] = '{0, 1, 2'b10};
        tbl[4] = '{0, 1, 2'b10};
        tbl[5] = '{1, 1, 2'b01};
        tbl[6] = '{1, 0, 2'b01};
        tbl[7] = '{1, 1, 2'b10};

        rst = 1'b1; m_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin sd[p] = '0; sv[p] = 0; sl[p] = 0; held[p] = 0; end
        @(posedge clk); @(posedge clk); #1;
        chk("reset_vector",
            32'({grant, sr0, sr1, m_valid, m_last, pkt_done, trunc, pkt_src, cnt0, cnt1}), 0);
        rst = 1'b0;
        model_reset();

        // single 4-beat packet on port 0
        stats_reset(); rmode = 0; vpct = 100;
        push_pkt(0, 4, 1);
        run_drain(40);
        chk("single_latency", 32'(first_beat_cyc - first_valid_cyc), 1);
        chk("single_beats", 32'(out_q.size()), 4);
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            chk("single_data", out_q[i], 32'(i + 1));
            chk("single_last", 32'(out_last[i]), 32'(i == 3));
        end
        chk("single_done_delay", 32'(done_cyc - last_beat_cyc), 1);
        chk("single_cnt0", 32'(cnt0), 1);
        chk("single_trunc", 32'(n_trunc), 0);

        // contention from reset
        do_reset(); stats_reset();
        push_pkt(0, 3, 0); push_pkt(0, 3, 3);
        push_pkt(1, 3, 0); push_pkt(1, 3, 3);
        run_drain(60);
        chk("cont_npkts", 32'(gnt_order.size()), 4);
        for (int i = 0; i < 4 && i < gnt_order.size(); i++)
            chk("cont_order", 32'(gnt_order[i]), 32'(i % 2));
        chk("cont_bubbles", 32'(bubbles), 3);
        bad = 0;
        for (int i = 0; i < out_q.size(); i++)
            if (out_q[i][31:24] != 8'((i / 3) % 2)) bad++;
        chk("cont_interleave", 32'(bad), 0);
        chk("cont_cnts", {cnt0, cnt1}, {2'd2, 2'd2});

        // backpressure on port 1, 5 beats
        do_reset(); stats_reset(); rmode = 1;
        push_pkt(1, 5, 16);
        run_drain(60);
        chk("bp_beats", 32'(out_q.size()), 5);
        for (int i = 0; i < 5 && i < out_q.size(); i++)
            chk("bp_data", out_q[i], {8'd1, 24'(16 + i)});
        chk("bp_s0_ready", 32'(s0r_seen), 0);

        // truncation at MAX_BEATS
        do_reset(); stats_reset(); rmode = 0;
        push_pkt(0, 6, 32);
        run_drain(60);
        chk("trunc_beats", 32'(out_q.size()), 6);
        for (int i = 0; i < 6 && i < out_last.size(); i++)
            chk("trunc_last", 32'(out_last[i]), 32'(i == 3 || i == 5));
        chk("trunc_pulses", 32'(n_trunc), 1);
        chk("trunc_done", 32'(n_done), 2);
        chk("trunc_cnt0", 32'(cnt0), 2);

        // counter wrap with CNT_W = 2
        do_reset(); stats_reset();
        for (int k = 0; k < 5; k++) push_pkt(1, 1, k);
        run_drain(80);
        chk("wrap_cnt1", 32'(cnt1), 1);
        chk("wrap_done", 32'(n_done), 5);

        // table: request patterns and the expected first grant
        do_reset();
        foreach (tbl[i]) begin
            stats_reset();
            if (tbl[i].r0) push_pkt(0, 1, 100 + i);
            if (tbl[i].r1) push_pkt(1, 1, 200 + i);
            run_drain(30);
            if (gnt_order.size() > 0)
                chk("tbl_first_grant", 32'(gnt_order[0] == 1 ? 2'b10 : 2'b01), 32'(tbl[i].exp_grant));
            else
                chk("tbl_first_grant", 0, 32'(tbl[i].exp_grant));
        end

        // asynchronous reset in the middle of a packet
        stats_reset();
        push_pkt(0, 1, 300);
        run_drain(20);
        stats_reset();
        push_pkt(0, 4, 400);
        begin
            int n = 0;
            while (out_q.size() < 2 && n < 50) begin cycle(); n++; end
            chk("mid_bound", 32'(n < 50), 1);
        end
        sv[0] = 1'b1; sd[0] = srcq[0][0].d; sl[0] = 1'b0; m_ready = 1'b1;
        #1;
        chk("mid_pre_ready", 32'({sr0, m_valid}), 32'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async_drop", 32'({sr0, sr1, m_valid, grant}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_src();
        model_reset();
        #1;
        chk("mid_after", 32'({grant, cnt0, cnt1, pkt_done, pkt_src}), 0);
        stats_reset();
        push_pkt(0, 1, 500); push_pkt(1, 1, 600);
        run_drain(30);
        chk("mid_first_grant", 32'(gnt_order.size() > 0 ? gnt_order[0] : -1), 0);

        // randomized traffic against the model
        stats_reset(); rmode = 2; vpct = 60;
        for (int k = 0; k < 20; k++) begin
            push_pkt(0, $urandom_range(1, 6), k * 16);
            push_pkt(1, $urandom_range(1, 6), k * 16);
        end
        run_drain(5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_stream_arbiter.md
# acc_stream_arbiter

Packet-granular round-robin arbiter that shares the single accumulator AXI-Stream input between two DMA MM2S streams. It sits between two slave AXI-Stream ports (from DMA channels) and the accumulator's s_axis port. It holds each grant for a whole packet (through tlast), so accumulator frames never interleave. It also enforces a maximum packet length and reports per-port packet completion counts and status pulses.

## Interface
Parameters:
- DATA_W, 32, stream data width.
- MAX_BEATS, 256, maximum beats per packet before forced termination; legal range 2..65535.
- CNT_W, 16, width of per-port packet counters.

Ports:
- axi_clk  in  1  single clock; all logic rising-edge.
- axi_rst  in  1  reset, asynchronous, active-high.
- s0_axis_data  in  DATA_W  port 0 data.
- s0_axis_valid  in  1  port 0 valid.
- s0_axis_last  in  1  port 0 last beat of packet.
- s0_axis_ready  out  1  port 0 ready.
- s1_axis_data / s1_axis_valid / s1_axis_last / s1_axis_ready: same as port 0, for port 1.
- m_axis_data  out  DATA_W  data toward the accumulator.
- m_axis_valid  out  1  valid toward the accumulator.
- m_axis_last  out  1  last toward the accumulator.
- m_axis_ready  in  1  accumulator ready.
- o_grant  out  2  one-hot current grant; 00 means idle.
- o_pkt_done  out  1  one-cycle pulse after a packet completes.
- o_pkt_src  out  1  source port of the most recent completed packet.
- o_trunc  out  1  one-cycle pulse, coincident with o_pkt_done, when a packet was force-terminated at MAX_BEATS.
- o_pkt_cnt0  out  CNT_W  completed-packet count, port 0.
- o_pkt_cnt1  out  CNT_W  completed-packet count, port 1.

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state is IDLE.
- Priority pointer last_srv resets to 1, so port 0 wins the first contention.
- IDLE transitions:
  - Both valid: grant the port != last_srv.
  - Only one valid: grant that port.
  - Neither valid: stay in IDLE.
- IDLE behavior: all readies 0, m_axis_valid 0.
- GNTx datapath (combinational, zero added latency):
  - m_axis_data = sx_axis_data; m_axis_valid = sx_axis_valid.
  - sx_axis_ready = m_axis_ready; the non-granted port's ready = 0.
- Beat: sx_valid & m_axis_ready in GNTx. A 16-bit beat counter increments per beat and clears on entry to IDLE.
- m_axis_last = sx_axis_last OR (beat counter == MAX_BEATS-1).
- Completion = a beat with m_axis_last = 1. On completion:
  - Next state IDLE; last_srv <= x; o_pkt_cntx increments (wraps at 2^CNT_W).
  - o_pkt_done = 1 and o_pkt_src = x on the next cycle.
  - o_trunc = 1 on that same cycle if sx_axis_last was 0.
- After truncation, the remaining source beats are treated as a new packet in a later grant; the arbiter does not discard them.
- Valid deasserting mid-packet (gap beats): grant is held indefinitely; there is no timeout.
- A request from the other port while GNTx is active is ignored until IDLE.
- Reset mid-packet, asynchronous:
  - State goes to IDLE; readies and m_axis_valid drop immediately.
  - Counters, pulses, and o_pkt_src clear; last_srv returns to 1.
  - The partial packet is lost; the system must reset the DMA as well.

## Timing
- Reset values: o_grant 00, all readies 0, m_axis_valid 0, m_axis_last 0, o_pkt_done 0, o_trunc 0, o_pkt_src 0, both counters 0.
- Arbitration latency: valid seen in IDLE at cycle N gives grant registered at N+1, so the first beat can transfer at N+1.
- Turnaround: exactly one IDLE bubble cycle after each completion before the next grant, so the next first beat is no earlier than completion+2.
- o_grant, o_pkt_*, and o_trunc are registered. Ready, valid, data, and last on the granted path are combinational through the mux.
- AXI-Stream rules: the arbiter never deasserts m_axis_valid without a handshake while granted, because it is passed through from the source.

## Test plan
- Single port 0 packet: 4 beats (1,2,3,4), last on beat 4, m_axis_ready = 1. Required response:
  - First beat transfers 1 cycle after valid rises.
  - m_axis_last on beat 4.
  - o_pkt_done and o_pkt_src = 0 one cycle later; o_pkt_cnt0 = 1.
- Contention: both ports hold 3-beat packets continuously from reset. Required response:
  - Grant order is 0,1,0,1.
  - One idle cycle between packets.
  - No interleaved beats.
  - After 4 packets, both counters = 2.
- Backpressure: m_axis_ready toggles every cycle during a port 1 packet of 5 beats. Required response:
  - Exactly 5 beats transfer with data order preserved.
  - s0_axis_ready stays 0 throughout.
- Truncation: MAX_BEATS = 4; port 0 sends 6 beats with last on beat 6. Required response:
  - Beat 4 carries m_axis_last = 1; o_trunc and o_pkt_done pulse.
  - Beats 5-6 form a second packet; o_pkt_cnt0 = 2 with one truncation.
- Reset mid-packet: assert axi_rst after beat 2 of 4. Required response:
  - Readies and m_axis_valid go to 0 in the same cycle, with no clock edge needed.
  - After release, o_grant = 00 and counters = 0.
  - With both ports valid, port 0 is granted first.
- Counter wrap: CNT_W = 2; send 5 single-beat packets on port 1. Required response: o_pkt_cnt1 = 1.
